// File: rtl/logic_probe_pulse_gen.sv
// logic_probe_pulse_gen
// Bus-programmable pulse generator that drives the logic probe's self-test path.
// It produces bursts of pulses with programmable high time, low time and count,
// or a continuous train. It raises a level interrupt when a finite burst completes.
//
// Ports:
//   clk             system clock
//   nreset          synchronous, active-low reset
//   address[2:0]    register select
//   data_in[31:0]   write data
//   data_out[31:0]  registered read data, valid while data_ready is high
//   data_request    one-cycle bus access strobe
//   write           1 = write, 0 = read (qualifies data_request)
//   data_ready      access acknowledge, one cycle after data_request
//   interrupt       burst-complete flag, level
//   interrupt_clear clears interrupt (a coincident completion wins)
//   gen_out         generated waveform, registered
//
// Register map:
//   0 HIGH_TIME  RW    1 LOW_TIME  RW    2 BURST RW (0 = continuous)
//   3 CONTROL    W: bit0 start, bit1 stop, bit2 idle_level; R: idle_level in bit2
//   4 STATUS     R: bit0 busy, bit1 interrupt
//   5 PULSE_CNT  R: completed pulses (saturating)
//   6-7          read 0, writes ignored
//
// FSM states:
//   state | meaning
//   IDLE  | no run in progress, gen_out follows idle_level
//   HIGH  | high phase of a pulse, phase_cnt counts down to 0
//   LOW   | low phase of a pulse, the pulse is counted when phase_cnt reaches 0

module logic_probe_pulse_gen #(
    parameter int COUNTERS_WIDTH = 24
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [2:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        data_request,
    input  logic        write,
    output logic        data_ready,
    output logic        interrupt,
    input  logic        interrupt_clear,
    output logic        gen_out
);

    localparam int W = COUNTERS_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   high_time, low_time, burst;
    logic [W-1:0]   phase_cnt, phase_nx;
    logic [W-1:0]   pulse_cnt, pulse_nx;
    logic [W-1:0]   high_load, low_load, pulse_inc;
    logic           idle_level, idle_level_nx;
    logic           gen_nx, irq_nx;
    logic           wr_en, rd_en, ctrl_wr;
    logic           start, stop;
    logic           busy, burst_done;
    logic [31:0]    rd_mux;

    // Bus decode
    assign wr_en   = data_request & write;
    assign rd_en   = data_request & ~write;
    assign ctrl_wr = wr_en && (address == 3'd3);
    // stop wins over start when both are written together
    assign start   = ctrl_wr & data_in[0] & ~data_in[1];
    assign stop    = ctrl_wr & data_in[1];

    // gen_out is registered from the next state, so an idle_level write must be
    // visible in the same cycle it lands in the register.
    assign idle_level_nx = ctrl_wr ? data_in[2] : idle_level;

    generate
        if (W < 32) begin : g_unused_upper
            logic unused_data_in;
            assign unused_data_in = ^data_in[31:W];
        end
    endgenerate

    // Configuration registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            high_time  <= '0;
            low_time   <= '0;
            burst      <= '0;
            idle_level <= 1'b0;
        end else begin
            if (wr_en) begin
                case (address)
                    3'd0:    high_time <= data_in[W-1:0];
                    3'd1:    low_time  <= data_in[W-1:0];
                    3'd2:    burst     <= data_in[W-1:0];
                    default: ;
                endcase
            end
            idle_level <= idle_level_nx;
        end
    end

    // Read mux samples the pre-edge values, so a PULSE_CNT read coincident with
    // an increment returns the old count.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(high_time);
            3'd1:    rd_mux = 32'(low_time);
            3'd2:    rd_mux = 32'(burst);
            3'd3:    rd_mux[2] = idle_level;
            3'd4:    begin
                         rd_mux[0] = busy;
                         rd_mux[1] = interrupt;
                     end
            3'd5:    rd_mux = 32'(pulse_cnt);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            data_ready <= 1'b0;
            data_out   <= '0;
        end else begin
            data_ready <= data_request;
            if (rd_en) begin
                data_out <= rd_mux;
            end
        end
    end

    // Phase reload values: a zero time register still gives a one-cycle phase
    assign high_load = (high_time == '0) ? '0 : high_time - W'(1);
    assign low_load  = (low_time == '0) ? '0 : low_time - W'(1);
    assign pulse_inc = (&pulse_cnt) ? pulse_cnt : pulse_cnt + W'(1);
    // BURST is compared live; >= lets a shrunken BURST end the run at the next LOW end
    assign burst_done = (burst != '0) && (pulse_inc >= burst);
    assign busy       = (state != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pulse_cnt <= '0;
            gen_out   <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
            pulse_cnt <= pulse_nx;
            gen_out   <= gen_nx;
            interrupt <= irq_nx;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nx = state;
        phase_nx = phase_cnt;
        pulse_nx = pulse_cnt;
        irq_nx   = interrupt & ~interrupt_clear;

        case (state)
            IDLE: ;
            HIGH: begin
                if (phase_cnt == '0) begin
                    state_nx = LOW;
                    phase_nx = low_load;
                end else begin
                    phase_nx = phase_cnt - W'(1);
                end
            end
            LOW: begin
                if (phase_cnt == '0) begin
                    pulse_nx = pulse_inc;
                    if (burst_done) begin
                        state_nx = IDLE;
                        irq_nx   = 1'b1;
                    end else begin
                        state_nx = HIGH;
                        phase_nx = high_load;
                    end
                end else begin
                    phase_nx = phase_cnt - W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Bus commands override the sequencing above
        if (stop) begin
            state_nx = IDLE;
            phase_nx = '0;
            pulse_nx = pulse_cnt;
            irq_nx   = interrupt & ~interrupt_clear;
        end else if (start) begin
            state_nx = HIGH;
            phase_nx = high_load;
            pulse_nx = '0;
            irq_nx   = 1'b0;
        end

        gen_nx = (state_nx == IDLE) ? idle_level_nx : (state_nx == HIGH);
    end

endmodule

// File: tb/tb_logic_probe_pulse_gen.sv
module tb_logic_probe_pulse_gen;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int BIG  = 32'h7fff_ffff;

    logic        clk;
    logic        nreset;
    logic [2:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_request;
    logic        write;
    logic        data_ready;
    logic        interrupt;
    logic        interrupt_clear;
    logic        gen_out;

    logic_probe_pulse_gen #(.COUNTERS_WIDTH(W)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .address         (address),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_request    (data_request),
        .write           (write),
        .data_ready      (data_ready),
        .interrupt       (interrupt),
        .interrupt_clear (interrupt_clear),
        .gen_out         (gen_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: bus responses and per-cycle waveform expectations
    typedef struct { int cyc; bit chk; logic [31:0] val; int addr; } rd_t;
    typedef struct { int cyc; int sig; logic val; } wv_t;   // sig 0 gen_out, 1 interrupt
    rd_t rd_q[$];
    wv_t wave_q[$];

    // Reference model: register mirror plus a description of the latest run
    int m_ht, m_lt, m_burst;
    bit m_idle;
    bit rs_valid;
    int rs_c, rs_p, rs_n, rs_stop, clr_edge;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Values below describe the DUT state right after clock edge number r
    function automatic int pulses_after(input int r);
        int e, k;
        if (!rs_valid) return 0;
        e = (r < rs_stop - 1) ? r : rs_stop - 1;
        if (e < rs_c + 1) return 0;
        k = (e - rs_c - 1) / rs_p;
        if (rs_n != 0 && k > rs_n) k = rs_n;
        if (k > MASK) k = MASK;
        return k;
    endfunction

    function automatic bit busy_after(input int r);
        if (!rs_valid || r >= rs_stop) return 1'b0;
        return (rs_n == 0) || (r <= rs_c + rs_n * rs_p);
    endfunction

    function automatic bit irq_after(input int r);
        int comp;
        comp = BIG;
        if (rs_valid && rs_n != 0 && (rs_c + rs_n * rs_p + 1) < rs_stop)
            comp = rs_c + rs_n * rs_p + 1;
        if (comp > r) return 1'b0;
        return !(clr_edge > comp && clr_edge <= r);
    endfunction

    function automatic logic [31:0] exp_read(input int a, input int r);
        logic [31:0] v;
        v = '0;
        case (a)
            0: v = m_ht;
            1: v = m_lt;
            2: v = m_burst;
            3: v[2] = m_idle;
            4: begin v[0] = busy_after(r); v[1] = irq_after(r); end
            5: v = pulses_after(r);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_ht = 0; m_lt = 0; m_burst = 0; m_idle = 1'b0;
        rs_valid = 1'b0; rs_c = 0; rs_p = 1; rs_n = 0; rs_stop = BIG; clr_edge = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flush_from(input int k);
        int i = 0;
        while (i < wave_q.size()) begin
            if (wave_q[i].cyc >= k) wave_q.delete(i);
            else i++;
        end
    endtask

    // Expected waveform of a run started by a CONTROL write issued at cycle c
    task automatic push_run(input int c, input int h1, input int h, input int l,
                            input int n, input bit idle, input int ncont);
        int t = c + 1;
        int hl;
        int ll = max1(l);
        wave_q.push_back('{t, 1, 1'b0});
        for (int k = 0; (n == 0) ? (t <= c + ncont) : (k < n); k++) begin
            hl = max1((k == 0) ? h1 : h);
            for (int i = 0; i < hl; i++) begin wave_q.push_back('{t, 0, 1'b1}); t++; end
            for (int i = 0; i < ll; i++) begin wave_q.push_back('{t, 0, 1'b0}); t++; end
        end
        if (n != 0) begin
            wave_q.push_back('{t, 0, idle});
            wave_q.push_back('{t, 1, 1'b1});
        end
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        rd_q.push_back('{cyc + 1, 1'b0, 32'd0, a});
        case (a)
            0: m_ht    = d & MASK;
            1: m_lt    = d & MASK;
            2: m_burst = d & MASK;
            default: ;
        endcase
        address = 3'(a); data_in = d; write = 1'b1; data_request = 1'b1;
        tick();
        data_request = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input int a, input logic [31:0] exp);
        rd_q.push_back('{cyc + 1, 1'b1, exp, a});
        address = 3'(a); data_in = $urandom; write = 1'b0; data_request = 1'b1;
        tick();
        data_request = 1'b0;
    endtask

    task automatic ctrl(input bit st, input bit sp, input bit idle, input int h1, input int hr);
        int c = cyc;
        logic [31:0] d;
        if (sp) begin
            rs_stop = c + 1;
            flush_from(c + 1);
            wave_q.push_back('{c + 1, 0, idle});
            wave_q.push_back('{c + 1, 1, irq_after(c + 1)});
            wave_q.push_back('{c + 2, 1, irq_after(c + 2)});
        end else if (st) begin
            rs_valid = 1'b1; rs_c = c; rs_p = max1(h1) + max1(m_lt); rs_n = m_burst;
            rs_stop = BIG; clr_edge = -1;
            flush_from(c + 1);
            push_run(c, h1, hr, m_lt, m_burst, idle, 12);
        end else if (!busy_after(c + 1)) begin
            wave_q.push_back('{c + 1, 0, idle});
        end
        m_idle = idle;
        d = ($urandom & 32'hFFFF_FFF8) | {29'd0, idle, sp, st};
        bus_write(3, d);
    endtask

    task automatic start_run(input bit idle);
        ctrl(1'b1, 1'b0, idle, m_ht, m_ht);
    endtask

    task automatic irq_clear_pulse();
        clr_edge = cyc + 1;
        wave_q.push_back('{cyc + 1, 1, irq_after(cyc + 1)});
        interrupt_clear = 1'b1;
        tick();
        interrupt_clear = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((wave_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (wave_q.size() != 0 || rd_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d wave and %0d bus items pending, required 0",
                     wave_q.size(), rd_q.size());
            wave_q.delete();
            rd_q.delete();
        end
    endtask

    // Monitor: pops expectations when the DUT presents a response or a cycle arrives
    rd_t r_item;
    wv_t w_item;
    int  wi;
    logic act;
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_ready cycle %0d: data_ready=1 required 0", cyc);
            end else begin
                r_item = rd_q.pop_front();
                checks++;
                if (r_item.cyc != cyc) begin
                    errors++;
                    $display("FAIL ready_latency addr %0d: ready at cycle %0d required %0d",
                             r_item.addr, cyc, r_item.cyc);
                end else if (r_item.chk) begin
                    if (data_out !== r_item.val) begin
                        errors++;
                        $display("FAIL read_addr%0d cycle %0d: got 0x%0h required 0x%0h",
                                 r_item.addr, cyc, data_out, r_item.val);
                    end
                end
            end
        end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_ready addr %0d cycle %0d: data_ready=%b required 1",
                     rd_q[0].addr, cyc, data_ready);
            void'(rd_q.pop_front());
        end

        wi = 0;
        while (wi < wave_q.size()) begin
            if (wave_q[wi].cyc <= cyc) begin
                w_item = wave_q[wi];
                wave_q.delete(wi);
                act = (w_item.sig == 0) ? gen_out : interrupt;
                checks++;
                if (w_item.cyc != cyc || act !== w_item.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %b required %b",
                             (w_item.sig == 0) ? "gen_out" : "interrupt", w_item.cyc, act, w_item.val);
                end
            end else begin
                wi++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        nreset = 1'b0; address = '0; data_in = '0; data_request = 1'b0;
        write = 1'b0; interrupt_clear = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_gen_out", 32'(gen_out), 32'd0);
        check("reset_interrupt", 32'(interrupt), 32'd0);
        check("reset_data_ready", 32'(data_ready), 32'd0);
        check("reset_data_out", data_out, 32'd0);
        nreset = 1'b1;
        tick();

        // 1: all addresses read zero, writes to read-only/unused addresses ignored
        for (int a = 0; a < 8; a++) bus_read(a, 32'd0);
        for (int a = 4; a < 8; a++) bus_write(a, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) bus_read(a, exp_read(a, cyc));
        wait_drain(20);

        // 2: 3/2 burst of 4
        bus_write(0, 32'hABCD_0003);
        bus_write(1, 2);
        bus_write(2, 4);
        bus_read(0, 32'd3);
        start_run(1'b0);
        wait_drain(60);
        bus_read(5, 32'd4);
        bus_read(4, 32'h2);
        wait_drain(10);

        // 3: continuous 1/1 toggling, saturation, stop (with start also set)
        bus_write(0, 0); bus_write(1, 0); bus_write(2, 0);
        c = cyc;
        start_run(1'b0);
        while (cyc < c + 7) tick();
        bus_read(5, exp_read(5, cyc));
        while (cyc < c + 530) tick();
        bus_read(5, exp_read(5, cyc));
        bus_read(4, exp_read(4, cyc));
        ctrl(1'b1, 1'b1, 1'b1, m_ht, m_ht);
        bus_read(4, exp_read(4, cyc));
        bus_read(5, exp_read(5, cyc));
        wait_drain(20);

        // 4: HIGH_TIME rewritten mid-high, then restart mid-burst
        bus_write(0, 5); bus_write(1, 2); bus_write(2, 3);
        c = cyc;
        ctrl(1'b1, 1'b0, 1'b0, 5, 2);
        tick();
        bus_write(0, 2);
        while (cyc < c + 8) tick();
        bus_read(5, exp_read(5, cyc));
        tick();
        start_run(1'b0);
        bus_read(5, exp_read(5, cyc));
        wait_drain(60);

        // 5: completion coincident with interrupt_clear, then clear alone, then idle_level
        bus_write(0, 2); bus_write(1, 1); bus_write(2, 2);
        c = cyc;
        start_run(1'b0);
        while (cyc < c + 6) tick();
        irq_clear_pulse();
        wave_q.push_back('{cyc + 1, 1, 1'b1});
        tick();
        irq_clear_pulse();
        ctrl(1'b0, 1'b0, 1'b1, m_ht, m_ht);
        bus_read(4, exp_read(4, cyc));
        bus_read(3, exp_read(3, cyc));
        wait_drain(20);

        // 6: reset in the middle of a LOW phase
        bus_write(0, 3); bus_write(1, 4); bus_write(2, 2);
        c = cyc;
        start_run(1'b1);
        tick();
        bus_read(4, exp_read(4, cyc));
        while (cyc < c + 5) tick();
        nreset = 1'b0;
        flush_from(c + 6);
        wave_q.push_back('{c + 6, 0, 1'b0});
        wave_q.push_back('{c + 6, 1, 1'b0});
        tick();
        model_reset();
        check("midrun_reset_data_out", data_out, 32'd0);
        check("midrun_reset_data_ready", 32'(data_ready), 32'd0);
        nreset = 1'b1;
        for (int k = 1; k <= 3; k++) wave_q.push_back('{cyc + k, 0, 1'b0});
        for (int a = 0; a < 6; a++) bus_read(a, exp_read(a, cyc));
        wait_drain(20);

        // Randomized bursts against the model
        for (int it = 0; it < 10; it++) begin
            int h, l, n, r, a, p;
            bit id;
            h  = $urandom_range(0, 4);
            l  = $urandom_range(0, 4);
            n  = $urandom_range(1, 4);
            id = 1'($urandom_range(0, 1));
            bus_write(0, ($urandom & 32'hFFFF_FF00) | h);
            bus_write(1, ($urandom & 32'hFFFF_FF00) | l);
            bus_write(2, ($urandom & 32'hFFFF_FF00) | n);
            c = cyc;
            start_run(id);
            p = max1(h) + max1(l);
            r = c + 1 + $urandom_range(0, n * p + 2);
            while (cyc < r) tick();
            a = $urandom_range(0, 5);
            bus_read(a, exp_read(a, cyc));
            wait_drain(100);
            bus_read(5, exp_read(5, cyc));
            bus_read(4, exp_read(4, cyc));
            if ($urandom_range(0, 1) == 1) irq_clear_pulse();
            wait_drain(10);
        end

        wait_drain(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_probe_pulse_gen.md
Name: logic_probe_pulse_gen

Overview:
Bus-programmable digital pulse generator, the stimulus-side companion to the logic probe. It drives a test waveform with programmable high time, low time and burst length onto the probe input path, so the probe's level and frequency counters can be self-tested and calibrated. It sits on the same CPU peripheral bus as the probe and raises an interrupt when a finite burst completes.

Parameters:
COUNTERS_WIDTH, 24, width of the high-time, low-time, burst-count and pulse-counter registers (max 32).

Ports:
clk  input  1  system clock
nreset  input  1  synchronous, active-low reset
address  input  3  register select
data_in  input  32  write data
data_out  output  32  read data, registered
data_request  input  1  bus access strobe, one cycle per access
write  input  1  qualifies data_request: 1=write, 0=read
data_ready  output  1  access acknowledge
interrupt  output  1  burst-complete flag, level
interrupt_clear  input  1  clears interrupt
gen_out  output  1  generated waveform

Behaviour:
- Reset (nreset=0 at clk edge): HIGH_TIME, LOW_TIME, BURST, pulse_cnt, phase_cnt=0; idle_level=0; state IDLE; gen_out=0; interrupt=0; data_ready=0; data_out=0.
- Register map:
  - 0 HIGH_TIME, RW.
  - 1 LOW_TIME, RW.
  - 2 BURST, RW; 0 means continuous.
  - 3 CONTROL, W: bit0 start, bit1 stop, bit2 idle_level. Reads return {29'b0, idle_level, 2'b0}.
  - 4 STATUS, R: bit0 busy, bit1 interrupt.
  - 5 PULSE_CNT, R: completed pulses.
  - 6-7 read 0, writes ignored.
  - Writes keep data_in[COUNTERS_WIDTH-1:0]; reads are zero-extended.
- Handshake:
  - data_ready <= data_request every cycle, giving 1-cycle latency, 1-cycle pulse.
  - Read data is valid in data_out in the same cycle that data_ready is high.
  - Writes take effect at the edge where data_request=1.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: gen_out=idle_level.
  - Start write → next edge: state HIGH, gen_out=1, phase_cnt=max(HIGH_TIME,1)-1, pulse_cnt=0, interrupt=0.
  - HIGH: when phase_cnt==0 → LOW, gen_out=0, phase_cnt=max(LOW_TIME,1)-1; otherwise phase_cnt decrements.
  - LOW: when phase_cnt==0 → pulse_cnt+1.
    - If BURST!=0 and pulse_cnt+1==BURST → IDLE, interrupt=1.
    - Otherwise → HIGH, reloading HIGH_TIME.
  - Result: high phase lasts max(HIGH_TIME,1) cycles and low phase lasts max(LOW_TIME,1) cycles. Period = sum of the two.
  - gen_out is registered and glitch-free.
- Time registers are sampled only at phase load. Writes during a run affect the next phase, not the current one.
- BURST write during a run: compared live. If the new BURST is ≤ pulse_cnt and nonzero, the burst ends at the next LOW end with interrupt.
- Start while busy: restart from HIGH with pulse_cnt=0.
- Stop (any state): IDLE at the next edge, gen_out=idle_level, no interrupt. If start and stop are both set in one write, stop wins.
- idle_level write while busy: no effect on gen_out until IDLE.
- pulse_cnt saturates at all-ones in continuous mode; no wrap.
- Interrupt:
  - Set on burst completion.
  - Cleared by interrupt_clear or by start.
  - Set and interrupt_clear in the same cycle → set wins.
- Simultaneous bus read of PULSE_CNT and increment: returns the pre-increment value.
- Reset mid-burst aborts immediately to reset values.

Test Plan:
1. Reset then read all addresses 0-7 → all return 0; data_ready is high exactly 1 cycle after each request.
2. HIGH_TIME=3, LOW_TIME=2, BURST=4, start → gen_out 1 for 3 cycles, then 0 for 2 cycles, repeated 4 times (20 cycles); interrupt rises on the last LOW end; PULSE_CNT=4; STATUS=0x2.
3. HIGH_TIME=0, LOW_TIME=0, BURST=0 → gen_out toggles every cycle (period 2); stop → gen_out=idle_level within 1 cycle; no interrupt; busy=0.
4. During a burst (HIGH_TIME=5), write HIGH_TIME=2 mid-high → current high stays 5 cycles, next high is 2 cycles; a start during the burst restarts with PULSE_CNT=0.
5. Burst completion coincident with interrupt_clear → interrupt=1. Then interrupt_clear alone → interrupt=0. Then idle_level=1 → gen_out=1 while IDLE.
6. nreset asserted mid-LOW phase → next edge gen_out=0, busy=0, all registers 0, interrupt=0.
